// File: rtl/bus_reg_file_if.sv
// Control-side handshake between the control unit and bus_reg_file.
// The tri-state data bus is kept as a plain inout port on the register file,
// so every bus driver resolves on a single net at the level that owns it.
interface bus_reg_file_if #(
  parameter int IDX_W = 4
) ();

  logic [IDX_W-1:0] index;
  logic             rEn;
  logic             wEn;
  logic             rd_valid;
  logic             err;

  // Control unit side: issues requests and watches the status outputs.
  modport master (
    output index,
    output rEn,
    output wEn,
    input  rd_valid,
    input  err
  );

  // Register file side: consumes requests and reports status.
  modport slave (
    input  index,
    input  rEn,
    input  wEn,
    output rd_valid,
    output err
  );

endinterface

// File: rtl/bus_reg_file.sv
// Parametrised register file on a shared tri-state data bus.
// Writes are level-sensitive and sampled on the rising clock edge. Reads latch
// the index, then drive the bus from the following cycle for as long as rEn
// stays high. The bus is released combinationally when rEn drops.
// Illegal accesses (bad index, rEn+wEn together, write while driving, write to
// a hardwired-zero register 0) produce a registered one-cycle err pulse.
module bus_reg_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  bus_reg_file_if.slave     ctrl,
  inout  wire  [DATA_W-1:0] bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_rdIdx;
  logic              r_err;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_idxInRange;
  logic              w_idxIsZeroReg;
  logic              w_idxWritable;
  logic              w_doWrite;
  logic              w_drive;
  logic [DATA_W-1:0] w_rdData;

  // An index is only usable if it names an implemented register.
  assign w_idxInRange   = (int'(ctrl.index) < NUM_REGS);
  assign w_idxIsZeroReg = (ZERO_REG != 0) && (ctrl.index == '0);
  assign w_idxWritable  = w_idxInRange && !w_idxIsZeroReg;

  // A write only lands from IDLE with a lone wEn on a writable register.
  assign w_doWrite = (r_state == IDLE) && ctrl.wEn && !ctrl.rEn && w_idxWritable;

  // The bus is owned while in DRIVE and the requester still holds rEn.
  assign w_drive = (r_state == DRIVE) && ctrl.rEn;

  assign bus           = w_drive ? w_rdData : {DATA_W{1'bz}};
  assign ctrl.rd_valid = w_drive;
  assign ctrl.err      = r_err;

  // Read mux on the latched index; out-of-range and hardwired-zero read as 0.
  always_comb begin
    w_rdData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((r_rdIdx == IDX_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
        w_rdData = r_regs[i];
      end
    end
  end

  // Register storage: cleared on reset, loaded from the bus on a legal write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_doWrite && (ctrl.index == IDX_W'(i))) begin
          r_regs[i] <= bus;
        end
      end
    end
  end

  // Read FSM with index latch and one-cycle err pulse on any illegal access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rdIdx <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ctrl.rEn && ctrl.wEn) begin
            r_err <= 1'b1;
          end else if (ctrl.rEn) begin
            r_rdIdx <= ctrl.index;
            r_state <= DRIVE;
            if (!w_idxInRange) begin
              r_err <= 1'b1;
            end
          end else if (ctrl.wEn) begin
            if (!w_idxWritable) begin
              r_err <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (ctrl.wEn) begin
            r_err <= 1'b1;
          end
          if (!ctrl.rEn) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_reg_file.sv
// Directed self-checking bench for bus_reg_file.
// Instance A uses a normal register 0, instance B hardwires register 0 to zero.
module tb_bus_reg_file;

  logic clk = 1'b0;
  logic reset;

  bus_reg_file_if #(.IDX_W(4)) ctrlA ();
  bus_reg_file_if #(.IDX_W(4)) ctrlB ();

  wire  [15:0] busA;
  wire  [15:0] busB;
  logic [15:0] tbDataA;
  logic [15:0] tbDataB;
  logic        tbDrvA;
  logic        tbDrvB;

  int assertCount = 0;
  int failCount   = 0;

  assign busA = tbDrvA ? tbDataA : 16'hzzzz;
  assign busB = tbDrvB ? tbDataB : 16'hzzzz;

  bus_reg_file #(.DATA_W(16), .NUM_REGS(4), .IDX_W(4), .ZERO_REG(0)) dutA (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrlA),
    .bus   (busA)
  );

  bus_reg_file #(.DATA_W(16), .NUM_REGS(4), .IDX_W(4), .ZERO_REG(1)) dutB (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrlB),
    .bus   (busB)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input bit useB, input logic [3:0] idx, input logic [15:0] data,
                          output logic errSeen);
    if (useB) begin
      ctrlB.index = idx; tbDataB = data; tbDrvB = 1'b1; ctrlB.wEn = 1'b1;
    end else begin
      ctrlA.index = idx; tbDataA = data; tbDrvA = 1'b1; ctrlA.wEn = 1'b1;
    end
    tick();
    errSeen = useB ? ctrlB.err : ctrlA.err;
    if (useB) begin
      ctrlB.wEn = 1'b0; tbDrvB = 1'b0;
    end else begin
      ctrlA.wEn = 1'b0; tbDrvA = 1'b0;
    end
  endtask

  task automatic readReg(input bit useB, input logic [3:0] idx, output logic [15:0] data,
                         output logic validReq, output logic validDrv,
                         output logic errDrv, output logic validOff);
    if (useB) begin
      ctrlB.index = idx; ctrlB.rEn = 1'b1;
    end else begin
      ctrlA.index = idx; ctrlA.rEn = 1'b1;
    end
    #1;
    validReq = useB ? ctrlB.rd_valid : ctrlA.rd_valid;
    tick();
    data     = useB ? busB : busA;
    validDrv = useB ? ctrlB.rd_valid : ctrlA.rd_valid;
    errDrv   = useB ? ctrlB.err : ctrlA.err;
    if (useB) ctrlB.rEn = 1'b0;
    else      ctrlA.rEn = 1'b0;
    #1;
    validOff = useB ? ctrlB.rd_valid : ctrlA.rd_valid;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic vr, vd, ed, vo;
    reset = 1'b1;
    ctrlA.index = 4'd1; ctrlA.rEn = 1'b1; ctrlA.wEn = 1'b1;
    tbDataA = 16'hDEAD; tbDrvA = 1'b1;
    tick();
    tick();
    assertCount++;
    if (ctrlA.err !== 1'b0 || ctrlA.rd_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs err=%b rd_valid=%b required 0 0", ctrlA.err, ctrlA.rd_valid);
    end
    reset = 1'b0;
    ctrlA.rEn = 1'b0; ctrlA.wEn = 1'b0; tbDrvA = 1'b0;
    tick();
    readReg(1'b0, 4'd1, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL reset_wins_write reg1=%h required 0000", d);
    end
    readReg(1'b0, 4'd2, d, vr, vd, ed, vo);
    assertCount++;
    if (vr !== 1'b0 || vd !== 1'b1 || d !== 16'h0000 || vo !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL first_read req_valid=%b drv_valid=%b data=%h off_valid=%b required 0 1 0000 0",
               vr, vd, d, vo);
    end
  endtask

  task automatic test_read_after_write();
    logic [15:0] d;
    logic vr, vd, ed, vo, e;
    writeReg(1'b0, 4'd1, 16'hBEEF, e);
    readReg(1'b0, 4'd1, d, vr, vd, ed, vo);
    assertCount++;
    if (e !== 1'b0 || vr !== 1'b0 || d !== 16'hBEEF || vd !== 1'b1 || vo !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL read_after_write err=%b req_valid=%b data=%h drv_valid=%b off_valid=%b required 0 0 beef 1 0",
               e, vr, d, vd, vo);
    end
  endtask

  task automatic test_write_during_drive();
    logic [15:0] d;
    logic vr, vd, ed, vo;
    ctrlA.index = 4'd1; ctrlA.rEn = 1'b1;
    tick();
    ctrlA.index = 4'd3; ctrlA.wEn = 1'b1;
    #1;
    assertCount++;
    if (busA !== 16'hBEEF || ctrlA.rd_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL drive_ignores_index bus=%h rd_valid=%b required beef 1", busA, ctrlA.rd_valid);
    end
    tick();
    assertCount++;
    if (ctrlA.err !== 1'b1 || busA !== 16'hBEEF) begin
      failCount++;
      $display("[TB] FAIL write_in_drive_err err=%b bus=%h required 1 beef", ctrlA.err, busA);
    end
    ctrlA.wEn = 1'b0;
    tick();
    assertCount++;
    if (ctrlA.err !== 1'b0 || busA !== 16'hBEEF || ctrlA.rd_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL err_single_pulse err=%b bus=%h rd_valid=%b required 0 beef 1",
               ctrlA.err, busA, ctrlA.rd_valid);
    end
    ctrlA.rEn = 1'b0;
    tick();
    readReg(1'b0, 4'd3, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL reg3_untouched reg3=%h required 0000", d);
    end
  endtask

  task automatic test_illegal_access();
    logic [15:0] d;
    logic vr, vd, ed, vo, e;
    writeReg(1'b0, 4'd0, 16'h5555, e);
    ctrlA.index = 4'd0; ctrlA.rEn = 1'b1; ctrlA.wEn = 1'b1;
    tbDataA = 16'hAAAA; tbDrvA = 1'b1;
    tick();
    assertCount++;
    if (ctrlA.err !== 1'b1 || ctrlA.rd_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ren_wen_conflict err=%b rd_valid=%b required 1 0", ctrlA.err, ctrlA.rd_valid);
    end
    ctrlA.rEn = 1'b0; ctrlA.wEn = 1'b0; tbDrvA = 1'b0;
    tick();
    assertCount++;
    if (ctrlA.err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL conflict_err_pulse err=%b required 0", ctrlA.err);
    end
    readReg(1'b0, 4'd0, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h5555) begin
      failCount++;
      $display("[TB] FAIL conflict_no_write reg0=%h required 5555", d);
    end
    writeReg(1'b0, 4'd4, 16'h7777, e);
    assertCount++;
    if (e !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL write_oob_err err=%b required 1", e);
    end
    readReg(1'b0, 4'd0, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h5555) begin
      failCount++;
      $display("[TB] FAIL oob_reg0_kept reg0=%h required 5555", d);
    end
    readReg(1'b0, 4'd2, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL oob_reg2_kept reg2=%h required 0000", d);
    end
    readReg(1'b0, 4'd5, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h0000 || vd !== 1'b1 || ed !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL read_oob data=%h rd_valid=%b err=%b required 0000 1 1", d, vd, ed);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic vr, vd, ed, vo, e1, e2;
    writeReg(1'b0, 4'd2, 16'h1111, e1);
    writeReg(1'b0, 4'd3, 16'h2222, e2);
    readReg(1'b0, 4'd2, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h1111 || e1 !== 1'b0 || e2 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_reg2 data=%h err=%b%b required 1111 00", d, e1, e2);
    end
    readReg(1'b0, 4'd3, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h2222 || ed !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_reg3_relatch data=%h err=%b required 2222 0", d, ed);
    end
  endtask

  task automatic test_zero_reg();
    logic [15:0] d;
    logic vr, vd, ed, vo, e;
    writeReg(1'b1, 4'd0, 16'hFFFF, e);
    assertCount++;
    if (e !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL zero_reg_write_err err=%b required 1", e);
    end
    readReg(1'b1, 4'd0, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h0000 || vd !== 1'b1 || ed !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL zero_reg_read data=%h rd_valid=%b err=%b required 0000 1 0", d, vd, ed);
    end
    writeReg(1'b1, 4'd1, 16'h0F0F, e);
    readReg(1'b1, 4'd1, d, vr, vd, ed, vo);
    assertCount++;
    if (d !== 16'h0F0F || e !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL zero_inst_reg1 data=%h err=%b required 0f0f 0", d, e);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] d;
    logic vr, vd, ed, vo;
    ctrlA.index = 4'd1; ctrlA.rEn = 1'b1;
    tick();
    assertCount++;
    if (busA !== 16'hBEEF) begin
      failCount++;
      $display("[TB] FAIL pre_reset_drive bus=%h required beef", busA);
    end
    reset = 1'b1;
    tick();
    assertCount++;
    if (ctrlA.rd_valid !== 1'b0 || ctrlA.err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_mid_read rd_valid=%b err=%b required 0 0", ctrlA.rd_valid, ctrlA.err);
    end
    reset = 1'b0;
    ctrlA.rEn = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      readReg(1'b0, 4'(i), d, vr, vd, ed, vo);
      assertCount++;
      if (d !== 16'h0000 || vd !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL post_reset_reg%0d data=%h rd_valid=%b required 0000 1", i, d, vd);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ctrlA.index = '0; ctrlA.rEn = 1'b0; ctrlA.wEn = 1'b0;
    ctrlB.index = '0; ctrlB.rEn = 1'b0; ctrlB.wEn = 1'b0;
    tbDataA = '0; tbDataB = '0; tbDrvA = 1'b0; tbDrvB = 1'b0;
    test_reset();
    test_read_after_write();
    test_write_during_drive();
    test_illegal_access();
    test_back_to_back();
    test_zero_reg();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
